distribute_1xn_cmd_flow_buf: RTL and testbench
==============================================

DISTRIBUTE_1XN_CMD_FLOW_BUF -- requirements
Module: distribute_1xn_cmd_flow_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one data word.
REQ-002 SHALL have parameter NUM_DATA_OUT, default 4, number of output ports (2..16).
REQ-003 SHALL have parameter IN_COMMAND_WIDTH, default 8, input command width; must be >= NUM_DATA_OUT.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, entries per output buffer (power of 2, >= 2).
REQ-005 SHALL have parameter DROP_CNT_WIDTH, default 8, width of the drop counter.
REQ-006 SHALL have localparam DESTINATION_TAG_WIDTH = NUM_DATA_OUT, and OUT_COMMAND_WIDTH = IN_COMMAND_WIDTH-NUM_DATA_OUT if that is > 0, else 1.
REQ-007 Ports, one clock, reset asynchronous active-low:
  clk  in  1  clock
  rst_n  in  1  asynchronous active-low reset
  i_en  in  1  acceptance enable
  i_valid  in  1  input word valid
  o_ready  out  1  block can accept the input word this cycle
  i_data_bus  in  DATA_WIDTH  input word
  i_cmd  in  IN_COMMAND_WIDTH  command; MSB NUM_DATA_OUT bits = destination mask
  o_valid  out  NUM_DATA_OUT  per-port output valid
  i_ready  in  NUM_DATA_OUT  per-port downstream ready
  o_data_bus  out  NUM_DATA_OUT*DATA_WIDTH  port k at [k*DATA_WIDTH +: DATA_WIDTH]
  o_cmd  out  NUM_DATA_OUT*OUT_COMMAND_WIDTH  stripped command, port k at [k*OUT_COMMAND_WIDTH +: OUT_COMMAND_WIDTH]
  o_drop_cnt  out  DROP_CNT_WIDTH  count of words dropped with a zero mask

Function
REQ-008 SHALL decode mask = i_cmd[IN_COMMAND_WIDTH-1 -: NUM_DATA_OUT]; bit k set routes the word to port k; multiple set bits = multicast.
REQ-009 SHALL forward i_cmd[IN_COMMAND_WIDTH-NUM_DATA_OUT-1:0] unchanged as the stripped command to every targeted port; when no bits remain, o_cmd per port SHALL be 1'b0.
REQ-010 SHALL contain one FIFO of FIFO_DEPTH entries per port, each entry holding {data, stripped command}.
REQ-011 SHALL drive o_ready = i_en AND (for every k with mask[k]=1, FIFO k not full); o_ready SHALL NOT depend combinationally on i_ready.
REQ-012 SHALL accept a word on a rising clk edge when i_valid AND o_ready; acceptance writes all targeted FIFOs in that same edge (atomic multicast, never partial).
REQ-013 SHALL, with mask = 0 and i_en = 1, assert o_ready, consume the word on i_valid, write no FIFO, and increment o_drop_cnt, saturating at all-ones.
REQ-014 SHALL, with i_en = 0, hold o_ready low and accept nothing; output FIFOs SHALL keep draining.
REQ-015 SHALL drive o_valid[k] = FIFO k not empty; o_data_bus/o_cmd port k = FIFO k head entry, all zeros when empty (dummy data {DATA_WIDTH{1'b0}}).
REQ-016 SHALL pop FIFO k on a rising edge when o_valid[k] AND i_ready[k]; o_valid/data SHALL hold stable while i_ready[k] = 0.
REQ-017 Latency: a word accepted at edge N SHALL be visible at an empty target port immediately after edge N (1 cycle); ports drain independently.
REQ-018 Push and pop on the same FIFO at the same edge SHALL both take effect, occupancy unchanged; a full FIFO SHALL still refuse the push that cycle (REQ-011).
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-020 Data ordering per port SHALL be strictly FIFO; no word is duplicated or lost except via REQ-013.

Reset
REQ-021 rst_n low SHALL asynchronously empty all FIFOs and force o_valid = 0, o_data_bus = 0, o_cmd = 0, o_drop_cnt = 0, o_ready = 0.
REQ-022 Reset asserted mid-operation SHALL discard all buffered words; first acceptance is possible at the first rising edge after rst_n deasserts with i_en = 1.

Verification
REQ-023 Unicast: NUM_DATA_OUT=4, IN_COMMAND_WIDTH=8, i_cmd=8'b0100_1010, data 32'hAAAAAAAA, all i_ready=1 -> next cycle o_valid=4'b0100, port2 data AAAAAAAA, port2 o_cmd=4'b1010, then o_valid=0.
REQ-024 Multicast backpressure: i_cmd mask 4'b1001, i_ready[3]=0, 5 words 1..5 -> 4 accepted, o_ready low on 5th; port0 drains 1..4 in order; raising i_ready[3] releases 1..4 on port3, then word 5 accepted to both ports.
REQ-025 Zero mask: 3 words with mask 0 -> no o_valid, o_drop_cnt=3; with DROP_CNT_WIDTH=2, 5 drops -> o_drop_cnt saturates at 3.
REQ-026 Full with simultaneous pop: port1 FIFO full, i_ready[1]=1, new word for port1 -> o_ready=0 that cycle, accepted next cycle, order preserved, no loss.
REQ-027 Enable/reset: i_en=0 with i_valid=1 -> o_ready=0, buffered words still drain; rst_n pulsed low with 2 words buffered -> o_valid=0 and o_data_bus=0 immediately, counters 0.
REQ-028 Last stage: IN_COMMAND_WIDTH=NUM_DATA_OUT=2, i_cmd=2'b10, data 32'hBBBBBBBB -> port1 valid with BBBBBBBB, o_cmd per port = 1'b0.

Source files
------------

// File: rtl/distribute_1xn_cmd_flow_buf_if.sv
// Handshake/bus bundle for distribute_1xn_cmd_flow_buf.
// The slave modport is the distributor's view; master is the driver's view.
interface distribute_1xn_cmd_flow_buf_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_DATA_OUT     = 4,
    parameter int IN_COMMAND_WIDTH = 8,
    parameter int DROP_CNT_WIDTH   = 8
);
    localparam int OUT_COMMAND_WIDTH =
        (IN_COMMAND_WIDTH - NUM_DATA_OUT > 0) ? (IN_COMMAND_WIDTH - NUM_DATA_OUT) : 1;

    // input side
    logic                                      i_en;
    logic                                      i_valid;
    logic                                      o_ready;
    logic [DATA_WIDTH-1:0]                     i_data_bus;
    logic [IN_COMMAND_WIDTH-1:0]               i_cmd;

    // output side
    logic [NUM_DATA_OUT-1:0]                   o_valid;
    logic [NUM_DATA_OUT-1:0]                   i_ready;
    logic [NUM_DATA_OUT*DATA_WIDTH-1:0]        o_data_bus;
    logic [NUM_DATA_OUT*OUT_COMMAND_WIDTH-1:0] o_cmd;

    // status
    logic [DROP_CNT_WIDTH-1:0]                 o_drop_cnt;

    modport slave (
        input  i_en, i_valid, i_data_bus, i_cmd, i_ready,
        output o_ready, o_valid, o_data_bus, o_cmd, o_drop_cnt
    );

    modport master (
        output i_en, i_valid, i_data_bus, i_cmd, i_ready,
        input  o_ready, o_valid, o_data_bus, o_cmd, o_drop_cnt
    );
endinterface

// File: rtl/distribute_1xn_cmd_flow_buf.sv
// 1-to-N command-routed distributor with one FIFO per output port.
// The command MSBs form a destination mask; the remaining bits travel with
// the word as the stripped command. Multicast writes are all-or-nothing,
// and words with an empty mask are consumed and counted as drops.
module distribute_1xn_cmd_flow_buf #(
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_DATA_OUT     = 4,
    parameter int IN_COMMAND_WIDTH = 8,
    parameter int FIFO_DEPTH       = 4,
    parameter int DROP_CNT_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    distribute_1xn_cmd_flow_buf_if.slave      bus
);
    localparam int DESTINATION_TAG_WIDTH = NUM_DATA_OUT;
    localparam int OUT_COMMAND_WIDTH =
        (IN_COMMAND_WIDTH - NUM_DATA_OUT > 0) ? (IN_COMMAND_WIDTH - NUM_DATA_OUT) : 1;
    localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int PTR_WIDTH   = ADDR_WIDTH + 1;
    localparam int ENTRY_WIDTH = DATA_WIDTH + OUT_COMMAND_WIDTH;

    logic [DESTINATION_TAG_WIDTH-1:0] mask;
    logic [OUT_COMMAND_WIDTH-1:0]     strip_cmd;
    logic [ENTRY_WIDTH-1:0]           entry_in;

    logic [ENTRY_WIDTH-1:0] mem    [NUM_DATA_OUT][FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr [NUM_DATA_OUT];
    logic [PTR_WIDTH-1:0]   rd_ptr [NUM_DATA_OUT];

    logic [NUM_DATA_OUT-1:0]   full;
    logic [NUM_DATA_OUT-1:0]   empty;
    logic [NUM_DATA_OUT-1:0]   push;
    logic [NUM_DATA_OUT-1:0]   pop;
    logic                      accept;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;
    logic [ENTRY_WIDTH-1:0]    head;

    assign mask = bus.i_cmd[IN_COMMAND_WIDTH-1 -: DESTINATION_TAG_WIDTH];

    // When the mask consumes the whole command there is nothing left to
    // forward, so the stripped command is a constant zero bit.
    if (IN_COMMAND_WIDTH > NUM_DATA_OUT) begin : g_strip
        assign strip_cmd = bus.i_cmd[IN_COMMAND_WIDTH-NUM_DATA_OUT-1:0];
    end else begin : g_no_strip
        assign strip_cmd = '0;
    end

    assign entry_in = {bus.i_data_bus, strip_cmd};

    // Ready only looks at targeted FIFOs' fullness, never at downstream
    // ready, so a pop in the same cycle does not free a slot early.
    assign bus.o_ready = rst_n & bus.i_en & ~|(mask & full);
    assign accept      = bus.i_valid & bus.o_ready;

    // Per-FIFO status and push/pop strobes.
    always_comb begin
        full  = '0;
        empty = '0;
        push  = '0;
        pop   = '0;
        for (int unsigned k = 0; k < NUM_DATA_OUT; k++) begin
            empty[k] = (wr_ptr[k] == rd_ptr[k]);
            full[k]  = (wr_ptr[k][ADDR_WIDTH] != rd_ptr[k][ADDR_WIDTH]) &&
                       (wr_ptr[k][ADDR_WIDTH-1:0] == rd_ptr[k][ADDR_WIDTH-1:0]);
            push[k]  = accept & mask[k];
            pop[k]   = ~empty[k] & bus.i_ready[k];
        end
    end

    // FIFO pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_DATA_OUT; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_DATA_OUT; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care while empty because the
    // outputs are forced to zero then.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_DATA_OUT; k++) begin
            if (push[k]) mem[k][wr_ptr[k][ADDR_WIDTH-1:0]] <= entry_in;
        end
    end

    // Saturating count of words consumed with an empty destination mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && (mask == '0) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign bus.o_drop_cnt = drop_cnt;

    // Present each FIFO head, or zeros when that FIFO is empty.
    always_comb begin
        bus.o_valid    = '0;
        bus.o_data_bus = '0;
        bus.o_cmd      = '0;
        head           = '0;
        for (int unsigned k = 0; k < NUM_DATA_OUT; k++) begin
            head = mem[k][rd_ptr[k][ADDR_WIDTH-1:0]];
            if (!empty[k]) begin
                bus.o_valid[k] = 1'b1;
                bus.o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] =
                    head[ENTRY_WIDTH-1 -: DATA_WIDTH];
                bus.o_cmd[k*OUT_COMMAND_WIDTH +: OUT_COMMAND_WIDTH] =
                    head[OUT_COMMAND_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_distribute_1xn_cmd_flow_buf.sv
// Bench for distribute_1xn_cmd_flow_buf: a 4-port instance driven by
// directed and random traffic against per-port queue models, plus a
// 2-port last-stage instance with a 2-bit drop counter.
module tb_distribute_1xn_cmd_flow_buf;
    typedef logic [35:0] entry_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    distribute_1xn_cmd_flow_buf_if #(
        .DATA_WIDTH(32), .NUM_DATA_OUT(4), .IN_COMMAND_WIDTH(8), .DROP_CNT_WIDTH(8)
    ) bus_a ();
    distribute_1xn_cmd_flow_buf_if #(
        .DATA_WIDTH(32), .NUM_DATA_OUT(2), .IN_COMMAND_WIDTH(2), .DROP_CNT_WIDTH(2)
    ) bus_b ();

    distribute_1xn_cmd_flow_buf #(
        .DATA_WIDTH(32), .NUM_DATA_OUT(4), .IN_COMMAND_WIDTH(8),
        .FIFO_DEPTH(4), .DROP_CNT_WIDTH(8)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    distribute_1xn_cmd_flow_buf #(
        .DATA_WIDTH(32), .NUM_DATA_OUT(2), .IN_COMMAND_WIDTH(2),
        .FIFO_DEPTH(4), .DROP_CNT_WIDTH(2)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int errors = 0;
    int checks = 0;

    entry_t q_a [4][$];
    int     drop_a = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_a();
        logic [3:0]   exp_valid;
        logic [127:0] exp_data;
        logic [15:0]  exp_cmd;
        entry_t       e;
        exp_valid = '0;
        exp_data  = '0;
        exp_cmd   = '0;
        for (int k = 0; k < 4; k++) begin
            if (q_a[k].size() > 0) begin
                e = q_a[k][0];
                exp_valid[k]        = 1'b1;
                exp_data[k*32 +: 32] = e[35:4];
                exp_cmd[k*4 +: 4]    = e[3:0];
            end
        end
        check("a_valid", bus_a.o_valid, exp_valid);
        check("a_data", bus_a.o_data_bus, exp_data);
        check("a_cmd", bus_a.o_cmd, exp_cmd);
        check("a_drop", bus_a.o_drop_cnt, drop_a);
    endtask

    // One clock of traffic on instance A, called and returning at a negedge.
    task automatic cycle_a(input logic en, input logic valid, input logic [31:0] data,
                           input logic [7:0] cmd, input logic [3:0] rdy, output logic acc);
        logic       exp_rdy;
        logic [3:0] mask;
        logic [3:0] pops;
        bus_a.i_en       = en;
        bus_a.i_valid    = valid;
        bus_a.i_data_bus = data;
        bus_a.i_cmd      = cmd;
        bus_a.i_ready    = rdy;
        #1;
        mask    = cmd[7:4];
        exp_rdy = en;
        for (int k = 0; k < 4; k++)
            if (mask[k] && q_a[k].size() >= 4) exp_rdy = 1'b0;
        check("a_ready", bus_a.o_ready, exp_rdy);
        acc = valid && exp_rdy;
        for (int k = 0; k < 4; k++) pops[k] = rdy[k] && (q_a[k].size() > 0);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (pops[k]) void'(q_a[k].pop_front());
            if (acc && mask[k]) q_a[k].push_back({data, cmd[3:0]});
        end
        if (acc && mask == 4'd0 && drop_a < 255) drop_a++;
        @(negedge clk);
        check_outputs_a();
    endtask

    task automatic cycle_b(input logic valid, input logic [31:0] data,
                           input logic [1:0] cmd, input logic [1:0] rdy);
        bus_b.i_en       = 1'b1;
        bus_b.i_valid    = valid;
        bus_b.i_data_bus = data;
        bus_b.i_cmd      = cmd;
        bus_b.i_ready    = rdy;
        #1;
        check("b_ready", bus_b.o_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse launched mid-cycle; outputs must clear at once.
    task automatic pulse_reset();
        bus_a.i_en    = 1'b1;
        bus_a.i_valid = 1'b0;
        bus_b.i_en    = 1'b1;
        bus_b.i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_a_valid", bus_a.o_valid, 4'd0);
        check("rst_a_data", bus_a.o_data_bus, 128'd0);
        check("rst_a_cmd", bus_a.o_cmd, 16'd0);
        check("rst_a_drop", bus_a.o_drop_cnt, 8'd0);
        check("rst_a_ready", bus_a.o_ready, 1'b0);
        check("rst_b_valid", bus_b.o_valid, 2'd0);
        check("rst_b_drop", bus_b.o_drop_cnt, 2'd0);
        check("rst_b_ready", bus_b.o_ready, 1'b0);
        for (int k = 0; k < 4; k++) q_a[k].delete();
        drop_a = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs_a();
    endtask

    initial begin
        logic acc;
        int   w;
        logic [3:0] m;

        rst_n = 1'b0;
        bus_a.i_en = 1'b0; bus_a.i_valid = 1'b0; bus_a.i_data_bus = '0;
        bus_a.i_cmd = '0;  bus_a.i_ready = '0;
        bus_b.i_en = 1'b0; bus_b.i_valid = 1'b0; bus_b.i_data_bus = '0;
        bus_b.i_cmd = '0;  bus_b.i_ready = '0;
        repeat (2) @(negedge clk);
        pulse_reset();

        // Unicast to port 2 with stripped command 1010.
        cycle_a(1'b1, 1'b1, 32'hAAAAAAAA, 8'b0100_1010, 4'hF, acc);
        check("uni_valid", bus_a.o_valid, 4'b0100);
        check("uni_data", bus_a.o_data_bus[95:64], 32'hAAAAAAAA);
        check("uni_cmd", bus_a.o_cmd[11:8], 4'b1010);
        cycle_a(1'b1, 1'b0, 32'h0, 8'h00, 4'hF, acc);
        check("uni_empty", bus_a.o_valid, 4'd0);

        // Multicast to ports 0 and 3 with port 3 stalled.
        w = 1;
        for (int c = 0; c < 8; c++) begin
            cycle_a(1'b1, w <= 5, w, 8'b1001_0000, 4'b0001, acc);
            if (acc) w++;
        end
        check("bp_accepted", w, 5);
        for (int c = 0; c < 10; c++) begin
            cycle_a(1'b1, w <= 5, w, 8'b1001_0000, 4'b1001, acc);
            if (acc) w++;
        end
        check("bp_done", w, 6);

        // Zero mask drops.
        for (int c = 0; c < 3; c++) cycle_a(1'b1, 1'b1, 32'hD0 + c, 8'h03, 4'hF, acc);
        check("drop3", bus_a.o_drop_cnt, 8'd3);

        // Port 1 full, then a new word while popping.
        for (int c = 0; c < 4; c++) cycle_a(1'b1, 1'b1, 32'h100 + c, 8'b0010_0101, 4'h0, acc);
        cycle_a(1'b1, 1'b1, 32'h200, 8'b0010_0110, 4'b0010, acc);
        check("full_ready", acc, 1'b0);
        cycle_a(1'b1, 1'b1, 32'h200, 8'b0010_0110, 4'b0010, acc);
        repeat (6) cycle_a(1'b1, 1'b0, 32'h0, 8'h00, 4'hF, acc);

        // Disabled input while buffered words drain.
        cycle_a(1'b1, 1'b1, 32'h300, 8'b0110_0001, 4'h0, acc);
        cycle_a(1'b1, 1'b1, 32'h301, 8'b0110_0010, 4'h0, acc);
        repeat (3) cycle_a(1'b0, 1'b1, 32'h3FF, 8'b1111_0000, 4'hF, acc);

        // Reset with words buffered.
        cycle_a(1'b1, 1'b1, 32'h400, 8'b1000_0001, 4'h0, acc);
        cycle_a(1'b1, 1'b1, 32'h401, 8'b1000_0010, 4'h0, acc);
        pulse_reset();

        // Random traffic, with one reset in the middle.
        for (int c = 0; c < 800; c++) begin
            m = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cycle_a($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom,
                    {m, 4'($urandom)}, 4'($urandom), acc);
            if (c == 400) pulse_reset();
        end

        // Last-stage instance: the whole command is the mask.
        cycle_b(1'b1, 32'hBBBBBBBB, 2'b10, 2'b00);
        check("last_valid", bus_b.o_valid, 2'b10);
        check("last_data", bus_b.o_data_bus, {32'hBBBBBBBB, 32'h0});
        check("last_cmd", bus_b.o_cmd, 2'b00);
        cycle_b(1'b0, 32'h0, 2'b00, 2'b11);
        check("last_empty", bus_b.o_valid, 2'b00);
        for (int i = 1; i <= 5; i++) begin
            cycle_b(1'b1, $urandom, 2'b00, 2'b11);
            check("b_drop_sat", bus_b.o_drop_cnt, (i < 3) ? i : 3);
            check("b_drop_novalid", bus_b.o_valid, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
